// File: rtl/priority_extractor.sv
// priority_extractor: emits each set bit of an accepted word as a one-hot beat (LSB- or MSB-first), first beat 1 cycle after accept.
// Valid/ready both sides, outputs hold while data_rdy_i is low; define PRIORITY_EXTRACTOR_INDEX_EN for the registered index_o port.
`timescale 1ns/1ps
module priority_extractor #(
  parameter int WIDTH = 16
`ifdef PRIORITY_EXTRACTOR_INDEX_EN
  ,
  localparam int IDX_W = $clog2(WIDTH)
`endif
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [WIDTH-1:0] onehot_o,
`ifdef PRIORITY_EXTRACTOR_INDEX_EN
  output logic [IDX_W-1:0] index_o,
`endif
  output logic             last_o,
  output logic             data_val_o,
  input  logic             data_rdy_i
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] onehot_d, cand, sel, rest;
  logic             dir_q, dir_d, last_d, cand_dir;
  logic             in_acc, out_acc;

  function automatic logic [WIDTH-1:0] sel_lsb(input logic [WIDTH-1:0] v);
    return v & (~v + WIDTH'(1));
  endfunction

  function automatic logic [WIDTH-1:0] sel_msb(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) s = WIDTH'(1) << i;
    end
    return s;
  endfunction

  assign data_val_o = (state_q == BUSY);

  always_comb begin
    out_acc    = data_val_o & data_rdy_i;
    // Combinational through data_rdy_i so a new word can load on the last beat's accept.
    data_rdy_o = (state_q == IDLE) | (out_acc & last_o);
    in_acc     = data_val_i & data_rdy_o;
    cand       = in_acc ? data_i : rem_q;
    cand_dir   = in_acc ? dir_i : dir_q;
    sel        = cand_dir ? sel_msb(cand) : sel_lsb(cand);
    rest       = cand & ~sel;

    state_d  = state_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    onehot_d = onehot_o;
    last_d   = last_o;

    if (in_acc) begin
      state_d  = BUSY;
      onehot_d = sel;
      rem_d    = rest;
      last_d   = (rest == '0);
      dir_d    = dir_i;
    end else if (out_acc) begin
      if (last_o) begin
        state_d = IDLE;
      end else begin
        onehot_d = sel;
        rem_d    = rest;
        last_d   = (rest == '0);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      onehot_o <= '0;
      last_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      onehot_o <= onehot_d;
      last_o   <= last_d;
    end
  end

`ifdef PRIORITY_EXTRACTOR_INDEX_EN
  function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) index_o <= '0;
    else           index_o <= encode(onehot_d);
  end
`endif

endmodule

// File: tb/tb_priority_extractor.sv
// Bench for priority_extractor: table vectors, hand-written corner sequences, then random traffic against a beat-queue model.
`timescale 1ns/1ps
module tb_priority_extractor;
  localparam int W = 16;

  logic         clk_i = 1'b0;
  logic         arst_n_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         dir_i = 1'b0;
  logic         data_val_i = 1'b0;
  logic         data_rdy_o;
  logic [W-1:0] onehot_o;
`ifdef PRIORITY_EXTRACTOR_INDEX_EN
  logic [3:0]   index_o;
`endif
  logic         last_o;
  logic         data_val_o;
  logic         data_rdy_i = 1'b0;

  int checks = 0;
  int errors = 0;

  priority_extractor #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .data_i     (data_i),
    .dir_i      (dir_i),
    .data_val_i (data_val_i),
    .data_rdy_o (data_rdy_o),
    .onehot_o   (onehot_o),
`ifdef PRIORITY_EXTRACTOR_INDEX_EN
    .index_o    (index_o),
`endif
    .last_o     (last_o),
    .data_val_o (data_val_o),
    .data_rdy_i (data_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0]        data;
    logic                dir;
    int                  n;
    logic [3:0][W-1:0]   beats;
  } vec_t;

  typedef struct {
    logic [W-1:0] oh;
    logic         last;
  } beat_t;

  vec_t  tbl[7];
  beat_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic int pos(input logic [W-1:0] oh);
    int p = 0;
    for (int i = 0; i < W; i++) if (oh[i]) p = i;
    return p;
  endfunction

  task automatic chk_beat(input string nm, input logic [W-1:0] oh, input logic lst);
    chk({nm, "_val"}, 32'(data_val_o), 32'(1));
    chk({nm, "_oh"}, 32'(onehot_o), 32'(oh));
    chk({nm, "_last"}, 32'(last_o), 32'(lst));
`ifdef PRIORITY_EXTRACTOR_INDEX_EN
    chk({nm, "_idx"}, 32'(index_o), 32'(pos(oh)));
`endif
  endtask

  // Reference: a word becomes the ordered list of its set bits (or one empty beat).
  task automatic push_word(input logic [W-1:0] w, input logic d);
    int n, k;
    beat_t b;
    n = $countones(w);
    k = 0;
    if (n == 0) begin
      b.oh = '0; b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int j = 0; j < W; j++) begin
        int i;
        i = d ? (W - 1 - j) : j;
        if (w[i]) begin
          k++;
          b.oh = W'(1) << i;
          b.last = (k == n);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // One cycle against the model; inputs already driven at the falling edge.
  task automatic model_cycle();
    logic exp_val, exp_rdy;
    #1;
    exp_val = (exp_q.size() != 0);
    exp_rdy = !exp_val || (data_rdy_i && exp_q[0].last);
    chk("rnd_val", 32'(data_val_o), 32'(exp_val));
    chk("rnd_rdy", 32'(data_rdy_o), 32'(exp_rdy));
    if (exp_val) begin
      chk("rnd_oh", 32'(onehot_o), 32'(exp_q[0].oh));
      chk("rnd_last", 32'(last_o), 32'(exp_q[0].last));
`ifdef PRIORITY_EXTRACTOR_INDEX_EN
      chk("rnd_idx", 32'(index_o), 32'(pos(exp_q[0].oh)));
`endif
    end
    if (exp_val && data_rdy_i) void'(exp_q.pop_front());
    if (data_val_i && exp_rdy) push_word(data_i, dir_i);
  endtask

  initial begin
    tbl[0] = '{16'h8421, 1'b0, 4, {16'h8000, 16'h0400, 16'h0020, 16'h0001}};
    tbl[1] = '{16'h8421, 1'b1, 4, {16'h0001, 16'h0020, 16'h0400, 16'h8000}};
    tbl[2] = '{16'h0000, 1'b0, 1, {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    tbl[3] = '{16'h8000, 1'b0, 1, {16'h0000, 16'h0000, 16'h0000, 16'h8000}};
    tbl[4] = '{16'h8000, 1'b1, 1, {16'h0000, 16'h0000, 16'h0000, 16'h8000}};
    tbl[5] = '{16'h0003, 1'b1, 2, {16'h0000, 16'h0000, 16'h0001, 16'h0002}};
    tbl[6] = '{16'h0006, 1'b0, 2, {16'h0000, 16'h0000, 16'h0004, 16'h0002}};

    // Reset state
    #2;
    chk("rst_val", 32'(data_val_o), 32'(0));
    chk("rst_oh", 32'(onehot_o), 32'(0));
    chk("rst_last", 32'(last_o), 32'(0));
`ifdef PRIORITY_EXTRACTOR_INDEX_EN
    chk("rst_idx", 32'(index_o), 32'(0));
`endif
    #6 arst_n_i = 1'b1;
    @(negedge clk_i); #1;
    chk("rst_rdy", 32'(data_rdy_o), 32'(1));

    // Table vectors, consumer always ready
    for (int t = 0; t < 7; t++) begin
      @(negedge clk_i);
      data_i = tbl[t].data; dir_i = tbl[t].dir; data_val_i = 1'b1; data_rdy_i = 1'b1;
      #1 chk($sformatf("tbl%0d_rdy", t), 32'(data_rdy_o), 32'(1));
      @(negedge clk_i);
      data_val_i = 1'b0; data_i = W'($urandom);
      for (int k = 0; k < tbl[t].n; k++) begin
        #1 chk_beat($sformatf("tbl%0d_b%0d", t, k), tbl[t].beats[k], k == tbl[t].n - 1);
        @(negedge clk_i);
      end
      #1 chk($sformatf("tbl%0d_end", t), 32'(data_val_o), 32'(0));
    end

    // Empty word followed back-to-back by 0xFFFF
    @(negedge clk_i);
    data_i = '0; dir_i = 1'b0; data_val_i = 1'b1; data_rdy_i = 1'b1;
    @(negedge clk_i);
    data_i = 16'hFFFF;
    #1 chk_beat("zero", '0, 1'b1);
    chk("zero_rdy", 32'(data_rdy_o), 32'(1));
    @(negedge clk_i);
    data_val_i = 1'b0;
    for (int k = 0; k < W; k++) begin
      #1 chk_beat($sformatf("ffff_b%0d", k), W'(1) << k, k == W - 1);
      @(negedge clk_i);
    end
    #1 chk("ffff_end", 32'(data_val_o), 32'(0));

    // Consumer stall on the first beat of 0x0006; a competing word must be ignored
    @(negedge clk_i);
    data_i = 16'h0006; dir_i = 1'b0; data_val_i = 1'b1; data_rdy_i = 1'b0;
    @(negedge clk_i);
    data_i = 16'h0100;
    for (int k = 0; k < 3; k++) begin
      #1 chk_beat($sformatf("stall%0d", k), 16'h0002, 1'b0);
      chk($sformatf("stall%0d_rdy", k), 32'(data_rdy_o), 32'(0));
      @(negedge clk_i);
    end
    data_val_i = 1'b0; data_rdy_i = 1'b1;
    #1 chk_beat("stall_rel", 16'h0002, 1'b0);
    @(negedge clk_i);
    #1 chk_beat("stall_b1", 16'h0004, 1'b1);
    @(negedge clk_i);
    #1 chk("stall_end", 32'(data_val_o), 32'(0));

    // Back-to-back 0x0003 then 0x0100
    data_i = 16'h0003; dir_i = 1'b0; data_val_i = 1'b1; data_rdy_i = 1'b1;
    @(negedge clk_i);
    data_i = 16'h0100;
    #1 chk_beat("b2b_b0", 16'h0001, 1'b0);
    chk("b2b_rdy0", 32'(data_rdy_o), 32'(0));
    @(negedge clk_i);
    #1 chk_beat("b2b_b1", 16'h0002, 1'b1);
    chk("b2b_rdy1", 32'(data_rdy_o), 32'(1));
    @(negedge clk_i);
    data_val_i = 1'b0;
    #1 chk_beat("b2b_b2", 16'h0100, 1'b1);
    @(negedge clk_i);
    #1 chk("b2b_end", 32'(data_val_o), 32'(0));

    // Asynchronous reset mid-word
    data_i = 16'hF000; dir_i = 1'b0; data_val_i = 1'b1; data_rdy_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
    #1 chk_beat("ar_b0", 16'h1000, 1'b0);
    #1 arst_n_i = 1'b0;
    #1;
    chk("ar_val", 32'(data_val_o), 32'(0));
    chk("ar_oh", 32'(onehot_o), 32'(0));
    chk("ar_last", 32'(last_o), 32'(0));
`ifdef PRIORITY_EXTRACTOR_INDEX_EN
    chk("ar_idx", 32'(index_o), 32'(0));
`endif
    #1 arst_n_i = 1'b1;
    @(negedge clk_i);
    #1 chk("ar_post_val", 32'(data_val_o), 32'(0));
    chk("ar_post_rdy", 32'(data_rdy_o), 32'(1));
    data_i = 16'h0010; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
    #1 chk_beat("ar_new", 16'h0010, 1'b1);
    @(negedge clk_i);
    #1 chk("ar_new_end", 32'(data_val_o), 32'(0));

    // Random traffic against the beat-queue model, then drain
    exp_q.delete();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_i);
      data_val_i = 1'($urandom_range(0, 1));
      dir_i      = 1'($urandom_range(0, 1));
      data_i     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom & $urandom & $urandom);
      data_rdy_i = ($urandom_range(0, 3) != 0);
      model_cycle();
    end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk_i);
      data_val_i = 1'b0; data_rdy_i = 1'b1;
      model_cycle();
    end
    chk("drain_val", 32'(data_val_o), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_extractor.md
# priority_extractor

Iterative, parametrised successor to the single-shot priority encoder. It accepts a WIDTH-bit word and emits every set bit of that word as a separate one-hot beat, one beat per accepted output cycle. The scan runs LSB-first or MSB-first, selected per word. Valid/ready handshakes on both sides let it sit between a request-vector producer (arbiters, interrupt/pending registers) and a serial consumer that services one request at a time.

## Interface
- WIDTH, 16: input word width; legal values are ≥ 2.
- IDX_W, $clog2(WIDTH): width of the index output. Derived; never overridden.
- clk_i  in  1  clock; all logic on the rising edge.
- arst_n_i  in  1  reset, asynchronous, active-low. Assertion clears state immediately; deassertion is synchronous to clk_i.
- data_i  in  WIDTH  request word; sampled on acceptance.
- dir_i  in  1  scan direction, sampled with data_i. 0 = LSB-first, 1 = MSB-first.
- data_val_i  in  1  input word valid.
- data_rdy_o  out  1  block can accept a word this cycle.
- onehot_o  out  WIDTH  current beat: exactly one bit set, or all-zero for an empty word.
- index_o  out  IDX_W  binary position of the onehot_o bit. Present only with the macro (see Configuration).
- last_o  out  1  current beat is the final beat of its word.
- data_val_o  out  1  output beat valid.
- data_rdy_i  in  1  consumer accepts the beat.

## Operation
- Input accept: data_val_i & data_rdy_o at a rising edge. Output accept: data_val_o & data_rdy_i at a rising edge.
- Two states:
  - IDLE: no beat pending.
  - BUSY: a beat is held on the outputs.
- Internal registers:
  - rem: the set bits of the word not yet emitted.
  - dir_q: the latched scan direction.
- Selection:
  - LSB-first: sel = v & (~v + 1).
  - MSB-first: sel = the highest set bit of v.
  - Both are computed combinationally on the candidate vector v.
- On input accept with v = data_i:
  - onehot_o <= sel(v); rem <= v & ~sel(v); last_o <= ((v & ~sel(v)) == 0).
  - dir_q <= dir_i; data_val_o <= 1; state becomes BUSY.
- Word of zero on input accept:
  - Emits one beat with onehot_o = 0, index_o = 0, last_o = 1.
  - Every accepted word therefore produces exactly one last beat.
- On output accept of a beat that is not last, with v = rem, using dir_q:
  - onehot_o <= sel(rem); rem <= rem & ~sel(rem); last_o <= ((rem & ~sel(rem)) == 0).
- On output accept of a last beat with no simultaneous input accept: data_val_o <= 0; state becomes IDLE.
- data_rdy_o = (state == IDLE) | (data_val_o & data_rdy_i & last_o).
  - This is combinational from data_rdy_i, to allow back-to-back words.
  - A simultaneous last-beat output accept and input accept loads the new word; data_val_o stays 1.
- While data_val_o = 1 and data_rdy_i = 0, all outputs are held stable.
- data_i and dir_i are ignored except on input accept.

## Timing
- Reset values: data_val_o = 0, onehot_o = 0, index_o = 0, last_o = 0, rem = 0, dir_q = 0, state = IDLE. data_rdy_o = 1 once reset is released.
- Latency: the first beat is valid in the cycle after input accept (1 cycle).
- Throughput, with data_rdy_i held high:
  - One beat per cycle.
  - A word with N set bits occupies N cycles (1 cycle if N = 0).
  - The next word follows with no bubble.
- Reset asserted mid-word: the word in progress is discarded and all outputs drop to their reset values asynchronously. No partial last beat is produced after reset.
- Boundary: a word with only bit WIDTH-1 set produces a single beat with last_o = 1 in either direction.

## Configuration
- PRIORITY_EXTRACTOR_INDEX_EN defined:
  - The index_o port exists.
  - It is registered alongside onehot_o and equals the binary encode of onehot_o (0 for an empty beat).
  - It has the same hold and reset behaviour as onehot_o.
- Undefined: the index_o port and its encoder logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=16, data_i=16'h8421, dir_i=0, data_rdy_i=1:
  - Beats 0x0001, 0x0020, 0x0400, 0x8000 on consecutive cycles; index 0, 5, 10, 15; last_o only on 0x8000.
- Same word, dir_i=1: beats 0x8000, 0x0400, 0x0020, 0x0001; index 15, 10, 5, 0.
- data_i=0: a single beat with onehot_o=0, last_o=1. Then data_i=16'hFFFF, LSB-first: 16 beats, 0x0001 through 0x8000, with no gap between the words.
- data_i=16'h0006, dir_i=0, data_rdy_i low for 3 cycles on the first beat:
  - onehot_o holds 0x0002 and data_rdy_o stays 0.
  - After release, 0x0004 with last_o=1 follows.
- Back-to-back: 16'h0003 then 16'h0100 presented continuously. data_rdy_o pulses high in the cycle of the last beat of 16'h0003; beats are 0x0001, 0x0002, 0x0100 in 3 consecutive cycles.
- arst_n_i pulsed low mid-word on data_i=16'hF000:
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, data_rdy_o=1 and no stale beat appears. A fresh 16'h0010 gives a single beat 0x0010 with last_o=1.
